instr_fetch: RTL

Fetch sequencer between the program counter and the instruction decoder.
- Each fetch samples the current PC address, issues a synchronous read to instruction memory and pulses the PC increment.
- Captures the returned word into an instruction register and hands it to decode over a valid/ready handshake.
- Supports flush on branch redirect (PC load) and stall when decode is busy.

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/instr_fetch.sv | 138 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch_state_e : fetch FSM state encoding
//   - DEF_AW/DEF_DW : default address / instruction word widths
//   - MAX_MEM_LAT   : largest supported instruction memory read latency
//   - LAT_W         : width of the read-latency down-counter
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int unsigned DEF_AW      = 5;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned MAX_MEM_LAT = 4;
  localparam int unsigned LAT_W       = $clog2(MAX_MEM_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no fetch in progress
    ST_ISSUE = 2'd1,  // read strobe + PC increment, exactly one cycle
    ST_WAIT  = 2'd2,  // waiting for the memory read data
    ST_HOLD  = 2'd3   // ir valid, waiting for decode to accept
  } fetch_state_e;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch sequencer between the program counter and the instruction decoder.
// Each fetch samples the PC, issues one synchronous read to instruction memory,
// pulses the PC increment, captures the returned word into the instruction
// register and presents it to decode over a valid/ready handshake.
// A flush (branch redirect) discards any in-flight or held instruction.
//
// Parameters:
//   AW      - instruction address width (matches the PC width)
//   DW      - instruction word width
//   MEM_LAT - instruction memory read latency in cycles, legal range 1..4
//
// Ports:
//   pclk        in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   fetch enable; low means no new fetch is issued
//   adpc        in   current program counter value
//   inc_pc      out  PC increment request, one pulse per issued fetch
//   imem_en     out  instruction memory read strobe
//   imem_addr   out  instruction memory read address
//   imem_rdata  in   read data, valid MEM_LAT cycles after imem_en
//   flush       in   redirect: drop in-flight/held instruction
//   ir          out  instruction register
//   ir_pc       out  address the instruction in ir was fetched from
//   ir_valid    out  ir/ir_pc hold a valid instruction
//   ir_ready    in   decode accepts ir this cycle
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] adpc,
  output logic          inc_pc,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          flush,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  fetch_state_e     state_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    ir_q;
  logic [AW-1:0]    ir_pc_q;
  logic             ir_valid_q;
  logic             issue_fire;

  // A flush in the ISSUE cycle cancels the read and the PC increment so the
  // PC load of the redirect is not disturbed.
  assign issue_fire = (state_q == ST_ISSUE) && !flush;

  assign inc_pc    = issue_fire;
  assign imem_en   = issue_fire;
  // The PC is presented straight through during ISSUE so the read starts in
  // the same cycle the PC is sampled; otherwise the last issued address holds.
  assign imem_addr = (state_q == ST_ISSUE) ? adpc : addr_q;

  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      // NOTE: the instruction register is a plain datapath register, so it is
      // reset like any other flop; being single-entry it carries no memory
      // reset cost and keeps ir deterministic straight out of reset.
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else if (flush) begin
      // Redirect: drop whatever is in flight or held. ir/ir_pc keep their old
      // contents; they are meaningless once ir_valid is low.
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ir_valid_q <= 1'b0;
          if (en) begin
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          addr_q    <= adpc;
          lat_cnt_q <= LAT_LOAD;
          state_q   <= ST_WAIT;
        end

        ST_WAIT: begin
          lat_cnt_q <= lat_cnt_q - LAT_ONE;
          // lat_cnt==1 marks cycle t+MEM_LAT, when the read data is valid.
          if (lat_cnt_q == LAT_ONE) begin
            ir_q       <= imem_rdata;
            ir_pc_q    <= addr_q;
            ir_valid_q <= 1'b1;
            state_q    <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // ir stays stable until decode takes it; en only gates the next
          // issue, never the hand-off of a fetch already in progress.
          if (ir_ready) begin
            ir_valid_q <= 1'b0;
            state_q    <= en ? ST_ISSUE : ST_IDLE;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule : instr_fetch
